// File: rtl/dma_copy_engine.sv
// dma_copy_engine: bus-master fill/copy engine for the SRAM controller DmaBus port.
// Moves 16-bit words (fill with a constant, or copy src->dst) one word at a time,
// holding dma_req for the whole transfer and keeping read and write strobes apart.
// Optional feature macro: DMA_CRC_EN adds a CRC-16/CCITT of every written word.
// All state advances on the falling edge of clk; reset is asynchronous, active low.
module dma_copy_engine #(
  parameter int unsigned RD_CYC = 2,
  parameter int unsigned WR_CYC = 2,
  parameter int unsigned LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [22:0]      src_addr,
  input  logic [22:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      fill_val,
  input  logic             abort,
  input  logic [15:0]      mem_dati,
  output logic             dma_req,
  output logic             dma_oe,
  output logic             dma_we_lo,
  output logic             dma_we_hi,
  output logic [22:0]      dma_addr,
  output logic [15:0]      dma_dato,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] words_left
`ifdef DMA_CRC_EN
  ,
  output logic [15:0]      crc
`endif
);

  localparam int unsigned CYC_MAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int unsigned CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_TA,
    S_WR,
    S_GAP,
    S_FIN
  } state_t;

  state_t           state;
  state_t           state_n;

  // Word addresses; the byte address is always {word, 1'b0}, so wrap is free.
  logic [21:0]      src_w;
  logic [21:0]      dst_w;
  logic [15:0]      data_q;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] wl;
  logic             mode_q;
  logic             abort_pend;
  logic             busy_q;
  logic             req_q;
  logic             done_q;
  logic             aborted_q;

  logic [LEN_W-1:0] wl_dec;
  logic             stop_req;
  logic             unused_addr_lsb;

  assign wl_dec          = wl - LEN_W'(1);
  assign stop_req        = abort_pend | abort;
  assign unused_addr_lsb = src_addr[0] ^ dst_addr[0];

`ifdef DMA_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic [15:0] dd;
    r  = c;
    dd = d;
    for (int unsigned i = 0; i < 16; i++) begin
      if (r[15] ^ dd[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else                r = {r[14:0], 1'b0};
      dd = {dd[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc = crc_q;
`endif

  assign dma_req    = req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign words_left = wl;

  // State register.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state decode and per-state bus strobes/address/data.
  always_comb begin
    state_n   = state;
    dma_oe    = 1'b0;
    dma_we_lo = 1'b0;
    dma_we_hi = 1'b0;
    dma_addr  = '0;
    dma_dato  = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)  state_n = S_FIN;
          else if (mode)  state_n = S_RD;
          else            state_n = S_WR;
        end
      end
      S_RD: begin
        dma_oe   = 1'b1;
        dma_addr = {src_w, 1'b0};
        if (cnt == RD_LAST) state_n = S_TA;
      end
      S_TA: begin
        dma_addr = {dst_w, 1'b0};
        dma_dato = data_q;
        state_n  = S_WR;
      end
      S_WR: begin
        dma_we_lo = 1'b1;
        dma_we_hi = 1'b1;
        dma_addr  = {dst_w, 1'b0};
        dma_dato  = data_q;
        if (cnt == WR_LAST) state_n = S_GAP;
      end
      S_GAP: begin
        dma_addr = {dst_w, 1'b0};
        dma_dato = data_q;
        if (wl_dec == '0 || stop_req) state_n = S_FIN;
        else if (mode_q)              state_n = S_RD;
        else                          state_n = S_WR;
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Command latch, word datapath, counters and status flags.
  // busy/dma_req are flops so a zero-length command still shows one busy clock
  // (in FIN); for real transfers they drop on the GAP->FIN edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_w      <= '0;
      dst_w      <= '0;
      data_q     <= '0;
      cnt        <= '0;
      wl         <= '0;
      mode_q     <= 1'b0;
      abort_pend <= 1'b0;
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
`ifdef DMA_CRC_EN
      crc_q      <= 16'hFFFF;
`endif
    end else begin
      done_q <= (state == S_FIN);
      if (busy_q && abort) abort_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_w      <= src_addr[22:1];
            dst_w      <= dst_addr[22:1];
            wl         <= len;
            mode_q     <= mode;
            data_q     <= fill_val;
            cnt        <= '0;
            busy_q     <= 1'b1;
            req_q      <= 1'b1;
            aborted_q  <= 1'b0;
            abort_pend <= 1'b0;
`ifdef DMA_CRC_EN
            crc_q      <= 16'hFFFF;
`endif
          end
        end
        S_RD: begin
          if (cnt == RD_LAST) begin
            data_q <= mem_dati;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WR: begin
          if (cnt == WR_LAST) cnt <= '0;
          else                cnt <= cnt + CNT_W'(1);
        end
        S_GAP: begin
          src_w <= src_w + 22'd1;
          dst_w <= dst_w + 22'd1;
          wl    <= wl_dec;
`ifdef DMA_CRC_EN
          crc_q <= crc16_word(crc_q, data_q);
`endif
          if (state_n == S_FIN) begin
            busy_q    <= 1'b0;
            req_q     <= 1'b0;
            aborted_q <= (wl_dec != '0);
          end
        end
        S_FIN: begin
          busy_q <= 1'b0;
          req_q  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: table-driven and randomized checks of dma_copy_engine against
// a word-list reference model and an SRAM model living in the bench.
module tb_dma_copy_engine;

  localparam int unsigned RD_CYC = 2;
  localparam int unsigned WR_CYC = 2;
  localparam int unsigned LEN_W  = 16;
  localparam int COPY_COST = RD_CYC + WR_CYC + 2;
  localparam int FILL_COST = WR_CYC + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [22:0]      src_addr;
  logic [22:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic [15:0]      fill_val;
  logic             abort;
  logic [15:0]      mem_dati;
  logic             dma_req;
  logic             dma_oe;
  logic             dma_we_lo;
  logic             dma_we_hi;
  logic [22:0]      dma_addr;
  logic [15:0]      dma_dato;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] words_left;
`ifdef DMA_CRC_EN
  logic [15:0]      crc;
`endif

  dma_copy_engine #(.RD_CYC(RD_CYC), .WR_CYC(WR_CYC), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .abort(abort), .mem_dati(mem_dati), .dma_req(dma_req), .dma_oe(dma_oe),
    .dma_we_lo(dma_we_lo), .dma_we_hi(dma_we_hi), .dma_addr(dma_addr),
    .dma_dato(dma_dato), .busy(busy), .done(done), .aborted(aborted),
`ifdef DMA_CRC_EN
    .crc(crc),
`endif
    .words_left(words_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        mode;
    logic [22:0] src;
    logic [22:0] dst;
    logic [15:0] len;
    logic [15:0] fill;
    int          abort_cyc;
    int          restart_cyc;
    int          exp_busy;
    int          exp_wl;
    logic        exp_ab;
    int          exp_writes;
  } vec_t;

  vec_t vecs[6];

  // SRAM seen by the DUT, and the reference model's view of the same memory.
  logic [15:0] sram [logic [21:0]];
  logic [15:0] mdl  [logic [21:0]];

  function automatic logic [15:0] dflt(input logic [21:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] sram_rd(input logic [21:0] a);
    if (sram.exists(a)) return sram[a];
    return dflt(a);
  endfunction

  function automatic logic [15:0] mdl_rd(input logic [21:0] a);
    if (mdl.exists(a)) return mdl[a];
    return dflt(a);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome of a command from the arithmetic word-cost rules.
  function automatic vec_t derive(input vec_t v);
    vec_t r;
    int   cost;
    int   n;
    r    = v;
    cost = v.mode ? COPY_COST : FILL_COST;
    n    = int'(v.len);
    if (v.abort_cyc > 0 && v.len != 0) begin
      n = (v.abort_cyc - 1) / cost + 1;
      if (n > int'(v.len)) n = int'(v.len);
    end
    r.exp_writes = n;
    r.exp_busy   = (v.len == 0) ? 1 : n * cost;
    r.exp_wl     = int'(v.len) - n;
    r.exp_ab     = (n < int'(v.len));
    return r;
  endfunction

  task automatic run_xfer(input vec_t v, input string tag);
    logic [37:0] exp_q[$];
    logic [37:0] got_q[$];
    logic [21:0] wa;
    logic [21:0] ra;
    logic [15:0] d;
    logic [37:0] e;
    logic [37:0] g;
    int busy_n, done_n, done_at, ovl_n, adj_n, req_n, post;
    logic prev_oe, prev_we, seen_done, ab_done;
    logic [LEN_W-1:0] wl_done, wl_first;

    // Reference model: sequential word list, copies read the model's memory.
    for (int i = 0; i < v.exp_writes; i++) begin
      wa = v.dst[22:1] + 22'(i);
      ra = v.src[22:1] + 22'(i);
      d  = v.mode ? mdl_rd(ra) : v.fill;
      mdl[wa] = d;
      exp_q.push_back({wa, d});
    end

    busy_n = 0; done_n = 0; done_at = -1; ovl_n = 0; adj_n = 0; req_n = 0; post = 0;
    prev_oe = 1'b0; prev_we = 1'b0; seen_done = 1'b0; ab_done = 1'b0;
    wl_done = '0; wl_first = '0;

    @(posedge clk);
    mode = v.mode; src_addr = v.src; dst_addr = v.dst; len = v.len; fill_val = v.fill;
    start = 1'b1;
    for (int k = 1; k <= 400 && post < 2; k++) begin
      @(posedge clk);
      if (k == 1) wl_first = words_left;
      if (busy) busy_n++;
      if (dma_req !== busy) req_n++;
      if (dma_oe && (dma_we_lo || dma_we_hi)) ovl_n++;
      if (dma_we_lo !== dma_we_hi) ovl_n++;
      if (dma_addr[0]) ovl_n++;
      if ((dma_oe && prev_we) || ((dma_we_lo || dma_we_hi) && prev_oe)) adj_n++;
      if (dma_we_lo && dma_we_hi && !prev_we) begin
        got_q.push_back({dma_addr[22:1], dma_dato});
        sram[dma_addr[22:1]] = dma_dato;
      end
      if (done) begin
        done_n++;
        if (!seen_done) begin
          done_at = k; wl_done = words_left; ab_done = aborted;
        end
        seen_done = 1'b1;
      end
      if (seen_done) post++;
      prev_oe  = dma_oe;
      prev_we  = dma_we_lo | dma_we_hi;
      mem_dati = dma_oe ? sram_rd(dma_addr[22:1]) : 16'h0000;
      start = 1'b0;
      abort = (k == v.abort_cyc);
      if (k == v.restart_cyc) begin
        start = 1'b1; mode = 1'b1; src_addr = 23'h003100; dst_addr = 23'h003000; len = 16'd7;
      end
    end
    start = 1'b0;
    abort = 1'b0;

    check({tag, " words_left_at_accept"}, wl_first, v.len);
    check({tag, " busy_clocks"}, busy_n, v.exp_busy);
    check({tag, " done_pulses"}, done_n, 1);
    check({tag, " done_time"}, done_at, (v.len == 0) ? 2 : v.exp_busy + 2);
    check({tag, " words_left"}, wl_done, v.exp_wl);
    check({tag, " aborted"}, ab_done, v.exp_ab);
    check({tag, " busy_after"}, busy, 0);
    check({tag, " strobe_overlap"}, ovl_n, 0);
    check({tag, " strobe_adjacent"}, adj_n, 0);
    check({tag, " req_vs_busy"}, req_n, 0);
    check({tag, " write_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = exp_q[i];
      g = got_q[i];
      check($sformatf("%s wr%0d_addr", tag, i), {g[37:16], 1'b0}, {e[37:16], 1'b0});
      check($sformatf("%s wr%0d_data", tag, i), g[15:0], e[15:0]);
    end
  endtask

  initial begin
    vec_t v;
    int   bad;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_val = '0; abort = 1'b0; mem_dati = '0;

    sram[22'h000800] = 16'h1111; sram[22'h000801] = 16'h2222;
    mdl[22'h000800]  = 16'h1111; mdl[22'h000801]  = 16'h2222;

    //            mode  src          dst          len    fill      abt rst busy wl ab wr
    vecs[0] = '{1'b0, 23'h000000, 23'h000100, 16'd3, 16'hA55A, -1, -1,  9, 0, 1'b0, 3};
    vecs[1] = '{1'b1, 23'h001000, 23'h002000, 16'd2, 16'h0000, -1, -1, 12, 0, 1'b0, 2};
    vecs[2] = '{1'b0, 23'h000000, 23'h000500, 16'd0, 16'hFFFF, -1, -1,  1, 0, 1'b0, 0};
    vecs[3] = '{1'b1, 23'h004000, 23'h005000, 16'd4, 16'h0000,  7, -1, 12, 2, 1'b1, 2};
    vecs[4] = '{1'b0, 23'h000000, 23'h7FFFFE, 16'd2, 16'h1234, -1, -1,  6, 0, 1'b0, 2};
    vecs[5] = '{1'b0, 23'h000000, 23'h000600, 16'd3, 16'hBEEF, -1,  3,  9, 0, 1'b0, 3};

    #1;
    check("reset dma_req", dma_req, 0);
    check("reset strobes", {dma_oe, dma_we_lo, dma_we_hi}, 0);
    check("reset dma_addr", dma_addr, 0);
    check("reset dma_dato", dma_dato, 0);
    check("reset busy_done_aborted", {busy, done, aborted}, 0);
    check("reset words_left", words_left, 0);

    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    check("fill mem 0x100", sram_rd(22'h000080), 16'hA55A);
    check("fill mem 0x104", sram_rd(22'h000082), 16'hA55A);
    check("copy mem 0x2000", sram_rd(22'h001000), 16'h1111);
    check("copy mem 0x2002", sram_rd(22'h001001), 16'h2222);
    check("wrap mem 0x7FFFFE", sram_rd(22'h3FFFFF), 16'h1234);
    check("wrap mem 0x000000", sram_rd(22'h000000), 16'h1234);
    check("restart not applied", sram.exists(22'h001800), 0);

    // abort while idle must not stick to the next transfer
    @(posedge clk); abort = 1'b1;
    @(posedge clk); abort = 1'b0;
    v = '{1'b0, 23'h0, 23'h000900, 16'd2, 16'h5AA5, -1, -1, 0, 0, 1'b0, 0};
    run_xfer(derive(v), "idle_abort");

    // reset in the middle of a write: outputs drop without a clock edge
    @(posedge clk);
    mode = 1'b0; dst_addr = 23'h700000; len = 16'd3; fill_val = 16'h0F0F; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    check("rst_pre we", {dma_req, dma_we_lo, dma_we_hi, busy}, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid dma_req", dma_req, 0);
    check("rst_mid we", {dma_we_lo, dma_we_hi}, 0);
    check("rst_mid busy", busy, 0);
    @(posedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      if (done || busy || dma_req) bad++;
    end
    check("rst_mid no_done", bad, 0);

    for (int r = 0; r < 24; r++) begin
      v.mode        = 1'($urandom_range(0, 1));
      v.src         = 23'(32'h10000 + 2 * $urandom_range(0, 32767));
      v.dst         = 23'(32'h20000 + 2 * $urandom_range(0, 32767));
      v.len         = 16'($urandom_range(0, 5));
      v.fill        = 16'($urandom);
      v.restart_cyc = -1;
      v.abort_cyc   = -1;
      if (v.len != 0 && $urandom_range(0, 2) == 0)
        v.abort_cyc = $urandom_range(1, int'(v.len) * (v.mode ? COPY_COST : FILL_COST));
      run_xfer(derive(v), $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Bus-master initiator for the DmaBus port of the SRAM controller.
- Generates dma_req plus oe/we_lo/we_hi/addr/data sequences that fill or copy word-aligned regions of the 16-bit cartridge SRAM.
- Receives read data back on the controller's data bus.
- Driven by the mapper/host command logic; reports busy/done and a word counter.

Parameters:
- RD_CYC, 2, clocks dma_oe is held per read (≥1); read data sampled on the last of these.
- WR_CYC, 2, clocks we strobes are held per write (≥1).
- LEN_W, 16, width of word-count field.

Ports:
- clk  in  1  system clock; all registers update on negedge clk
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-clock command strobe
- mode  in  1  0=fill, 1=copy
- src_addr  in  23  copy source byte address (bit0 ignored)
- dst_addr  in  23  destination byte address (bit0 ignored)
- len  in  LEN_W  transfer length in 16-bit words
- fill_val  in  16  fill data
- abort  in  1  stop request
- mem_dati  in  16  SRAM read data
- dma_req  out  1  bus ownership request to SRAM controller
- dma_oe  out  1  read strobe, active high
- dma_we_lo  out  1  low-byte write strobe, active high
- dma_we_hi  out  1  high-byte write strobe, active high
- dma_addr  out  23  byte address, bit0 always 0
- dma_dato  out  16  write data
- busy  out  1  transfer in progress
- done  out  1  one-clock completion pulse
- aborted  out  1  status of last transfer, valid from done
- words_left  out  LEN_W  remaining word count

Behaviour:
- Reset (rst_n=0, async): state IDLE. All outputs 0; internal addresses, data latch and counters cleared.
- States:
  - IDLE
  - RD: dma_oe=1, addr=src, RD_CYC clocks
  - TA: 1 clock, all strobes 0, addr=dst
  - WR: we_lo=we_hi=1, addr=dst, data driven, WR_CYC clocks
  - GAP: 1 clock, strobes 0, addr and data held
  - FIN: 1 clock
- start accepted only in IDLE. Latches src, dst, len, fill_val, mode; sets busy=1 and dma_req=1 on the same edge; words_left=len.
- start while busy is ignored.
- len=0: IDLE→FIN directly. No strobe is ever asserted; done fires the following clock.
- Per-word entry state:
  - copy enters RD
  - fill enters WR with dma_dato=fill_val
- In RD, mem_dati is captured on the edge ending the last RD clock. dma_dato takes that value from TA onward.
- After GAP:
  - src and dst increment by 2, modulo 2^23 (wrap 0x7FFFFE→0x000000).
  - words_left decrements.
  - If words_left becomes 0, or abort is pending, go to FIN; otherwise start the next word.
- Word cost: copy = RD_CYC+WR_CYC+2 clocks; fill = WR_CYC+1 clocks.
- No two strobes are ever active in the same clock. dma_oe and we strobes are always separated by ≥1 idle clock.
- abort: sticky once seen while busy. It takes effect only at the GAP→next boundary, so no write is ever truncated. If asserted in IDLE it is ignored.
- FIN: dma_req=0, busy=0, done=1 for exactly one clock, aborted=1 if abort stopped the transfer.
  - aborted holds until the next accepted start, which clears it.
  - words_left holds its remaining value.
- dma_req stays 1 continuously from accept until FIN. The SRAM controller's CPU path is muxed out for the whole transfer.
- Reset mid-transfer: strobes and dma_req drop asynchronously. The partial word is lost; no done pulse.

Optional Feature:
- Macro: DMA_CRC_EN.
- Defined:
  - Adds output crc [15:0], CRC-16/CCITT, poly 0x1021, init 0xFFFF, reset to 0xFFFF.
  - crc is re-initialised to 0xFFFF on accepted start.
  - It is updated once per completed word (in GAP) with the word written, MSB first.
  - Final value is valid when done=1.
- Undefined: no crc port; logic and timing are otherwise identical.

Test Plan:
- Fill, dst=0x000100, len=3, fill_val=0xA55A (WR_CYC=2):
  - writes 0xA55A to 0x100, 0x102, 0x104; busy for 9 clocks; done single pulse; words_left=0; aborted=0.
- Copy, src=0x001000 (preloaded 0x1111, 0x2222), dst=0x002000, len=2, RD_CYC=2:
  - 0x2000=0x1111, 0x2002=0x2222; 12 busy clocks; dma_oe never overlaps we.
- len=0 start:
  - dma_oe/we never asserted; done pulses 2 clocks after start; busy 1 clock.
- Copy len=4, abort raised during word 2's RD:
  - word 2 fully written; no further strobes; done with aborted=1; words_left=2.
- Wrap: fill dst=0x7FFFFE, len=2:
  - writes at 0x7FFFFE then 0x000000.
- Second start issued while busy:
  - ignored; original transfer completes unchanged.
- rst_n low during WR:
  - dma_req, dma_we_lo, dma_we_hi go 0 immediately without clock; busy=0; no done pulse.
